// File: rtl/sync_peak_detector.sv
// Correlation peak detector: threshold trigger, fixed search window, peak/offset report, holdoff.
// Define SYNC_PEAK_SIGNED_EN for signed mode (only positive peaks trigger or win).
module sync_peak_detector #(
   parameter int pDAT_W   = 12,
   parameter int pWIN_LEN = 16,
   parameter int pHOLDOFF = 64,
   localparam int OFF_W   = (pWIN_LEN > 1) ? $clog2(pWIN_LEN) : 1
) (
   input  logic                     iclk,
   input  logic                     irst_n,
   input  logic                     iena,
   input  logic signed [pDAT_W-1:0] idat,
   input  logic [pDAT_W-1:0]        ithreshold,
   output logic                     osync,
   output logic [pDAT_W-1:0]        opeak,
   output logic [OFF_W-1:0]         ooffset,
   output logic                     obusy
);

   localparam int HOLD_W = (pHOLDOFF > 1) ? $clog2(pHOLDOFF) : 1;
   localparam logic [OFF_W-1:0]  LAST_POS  = OFF_W'(pWIN_LEN - 1);
   localparam logic [OFF_W-1:0]  ONE_POS   = OFF_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((pHOLDOFF > 0) ? pHOLDOFF - 1 : 0);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      TRACK   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic [pDAT_W-1:0]   r_mag;
   logic                r_ena1;
   logic [OFF_W-1:0]    r_winCnt;
   logic [HOLD_W-1:0]   r_holdCnt;
   logic [pDAT_W-1:0]   r_peak;
   logic [OFF_W-1:0]    r_peakOff;
   logic                r_osync;
   logic [pDAT_W-1:0]   r_opeak;
   logic [OFF_W-1:0]    r_ooffset;
   logic [pDAT_W-1:0]   w_stage1Dat;
   logic                w_trigHit;
   logic                w_newPeak;
   logic                w_blockRetrig;
   logic                w_start;
   logic                w_close;
   logic [pDAT_W-1:0]   w_finalPeak;
   logic [OFF_W-1:0]    w_finalOff;
   logic                w_busy;

`ifdef SYNC_PEAK_SIGNED_EN
   assign w_stage1Dat = idat;
   assign w_trigHit   = $signed(r_mag) > $signed(ithreshold);
   assign w_newPeak   = $signed(r_mag) > $signed(r_peak);
`else
   // Two's complement negate; the most negative input maps to 2^(W-1) unsigned.
   assign w_stage1Dat = idat[pDAT_W-1] ? -idat : idat;
   assign w_trigHit   = r_mag > ithreshold;
   assign w_newPeak   = r_mag > r_peak;
`endif

   // With a one-sample window and no holdoff a back-to-back trigger would repeat the strobe.
   assign w_blockRetrig = (pWIN_LEN == 1 && pHOLDOFF == 0) ? r_osync : 1'b0;

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         r_mag  <= '0;
         r_ena1 <= 1'b0;
      end else begin
         r_mag  <= w_stage1Dat;
         r_ena1 <= iena;
      end
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         r_state <= SEARCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_start     = 1'b0;
      w_close     = 1'b0;
      if (r_ena1) begin
         case (r_state)
            SEARCH: begin
               if (w_trigHit && !w_blockRetrig) begin
                  w_start = 1'b1;
                  if (pWIN_LEN == 1) begin
                     w_close     = 1'b1;
                     w_nextState = (pHOLDOFF == 0) ? SEARCH : HOLDOFF;
                  end else begin
                     w_nextState = TRACK;
                  end
               end
            end
            TRACK: begin
               if (r_winCnt == LAST_POS) begin
                  w_close     = 1'b1;
                  w_nextState = (pHOLDOFF == 0) ? SEARCH : HOLDOFF;
               end
            end
            HOLDOFF: begin
               if (r_holdCnt == HOLD_LAST) begin
                  w_nextState = SEARCH;
               end
            end
            default: w_nextState = SEARCH;
         endcase
      end
   end

   always_comb begin
      w_busy = 1'b0;
      if (r_state == TRACK || r_state == HOLDOFF) begin
         w_busy = 1'b1;
      end
   end

   // The closing sample may itself be the new peak, so fold it in before reporting.
   always_comb begin
      w_finalPeak = r_peak;
      w_finalOff  = r_peakOff;
      if (r_state == SEARCH) begin
         w_finalPeak = r_mag;
         w_finalOff  = '0;
      end else if (w_newPeak) begin
         w_finalPeak = r_mag;
         w_finalOff  = r_winCnt;
      end
   end

   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         r_winCnt  <= '0;
         r_holdCnt <= '0;
         r_peak    <= '0;
         r_peakOff <= '0;
         r_osync   <= 1'b0;
         r_opeak   <= '0;
         r_ooffset <= '0;
      end else begin
         r_osync <= w_close;
         if (w_start) begin
            r_peak    <= r_mag;
            r_peakOff <= '0;
            r_winCnt  <= ONE_POS;
         end else if (r_ena1 && r_state == TRACK) begin
            if (w_newPeak) begin
               r_peak    <= r_mag;
               r_peakOff <= r_winCnt;
            end
            r_winCnt <= r_winCnt + ONE_POS;
         end
         if (w_close) begin
            r_holdCnt <= '0;
            r_opeak   <= w_finalPeak;
            r_ooffset <= w_finalOff;
         end else if (r_ena1 && r_state == HOLDOFF) begin
            r_holdCnt <= r_holdCnt + HOLD_ONE;
         end
      end
   end

   assign osync   = r_osync;
   assign opeak   = r_opeak;
   assign ooffset = r_ooffset;
   assign obusy   = w_busy;

endmodule

// File: tb/tb_sync_peak_detector.sv
// Scoreboard bench for sync_peak_detector: window-level reference model feeds an expectation
// queue; a negedge monitor checks every osync event and obusy on every cycle.
module tb_sync_peak_detector;

   localparam int W    = 12;
   localparam int WIN  = 8;
   localparam int HOLD = 4;
   localparam int OFFW = 3;
   localparam int MAXC = 8192;

   logic                iclk = 1'b0;
   logic                irst_n;
   logic                iena;
   logic signed [W-1:0] idat;
   logic [W-1:0]        ithreshold;
   logic                osync;
   logic [W-1:0]        opeak;
   logic [OFFW-1:0]     ooffset;
   logic                obusy;

   sync_peak_detector #(
      .pDAT_W  (W),
      .pWIN_LEN(WIN),
      .pHOLDOFF(HOLD)
   ) dut (
      .iclk      (iclk),
      .irst_n    (irst_n),
      .iena      (iena),
      .idat      (idat),
      .ithreshold(ithreshold),
      .osync     (osync),
      .opeak     (opeak),
      .ooffset   (ooffset),
      .obusy     (obusy)
   );

   always #5 iclk = ~iclk;

   int cyc = 0;
   always @(posedge iclk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int peak;
      int off;
   } exp_t;

   exp_t expQ[$];
   bit   busyAt[MAXC];
   bit   monOn = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;

   // Reference model state: collected window magnitudes and remaining holdoff samples.
   int   winMags[$];
   bit   collecting = 1'b0;
   int   holdLeft = 0;

   function automatic int magOf(logic [W-1:0] d);
`ifdef SYNC_PEAK_SIGNED_EN
      return int'($signed(d));
`else
      return d[W-1] ? (1 << W) - int'(d) : int'(d);
`endif
   endfunction

   function automatic int thrOf(logic [W-1:0] t);
`ifdef SYNC_PEAK_SIGNED_EN
      return int'($signed(t));
`else
      return int'(t);
`endif
   endfunction

   task automatic checkOutput(input string name, input int act, input int want);
      testsRun++;
      if (act != want) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, want);
      end
   endtask

   task automatic modelSample(input int m, input int issue);
      int bi;
      if (holdLeft > 0) begin
         holdLeft--;
      end else if (!collecting) begin
         if (m > thrOf(ithreshold)) begin
            collecting = 1'b1;
            winMags.delete();
            winMags.push_back(m);
         end
      end else begin
         winMags.push_back(m);
      end
      if (collecting && winMags.size() == WIN) begin
         bi = 0;
         for (int i = 1; i < WIN; i++) begin
            if (winMags[i] > winMags[bi]) bi = i;
         end
         expQ.push_back('{cyc: issue + 2, peak: winMags[bi], off: bi});
         collecting = 1'b0;
         holdLeft   = HOLD;
         winMags.delete();
      end
   endtask

   task automatic applyStimulus(input bit ena, input logic [W-1:0] d);
      @(posedge iclk);
      #1;
      iena = ena;
      idat = d;
      if (ena) modelSample(magOf(d), cyc);
      busyAt[cyc + 2] = collecting || (holdLeft > 0);
   endtask

   task automatic doReset(input logic [W-1:0] thr);
      applyStimulus(1'b0, '0);
      applyStimulus(1'b0, '0);
      @(posedge iclk);
      #1;
      irst_n = 1'b0;
      iena   = 1'b0;
      idat   = '0;
      collecting = 1'b0;
      holdLeft   = 0;
      winMags.delete();
      busyAt[cyc + 1] = 1'b0;
      busyAt[cyc + 2] = 1'b0;
      @(posedge iclk);
      #1;
      irst_n     = 1'b1;
      ithreshold = thr;
      busyAt[cyc + 2] = 1'b0;
   endtask

   always @(negedge iclk) begin
      if (monOn) begin
         exp_t e;
         checkOutput("obusy", int'(obusy), int'(busyAt[cyc]));
         if (osync) begin
            if (expQ.size() == 0) begin
               testsRun++;
               testsFailed++;
               $display("[TB] FAIL unexpected_sync at cycle %0d: got osync=1, expected 0", cyc);
            end else begin
               e = expQ.pop_front();
               checkOutput("sync_cycle", cyc, e.cyc);
               checkOutput("opeak", int'(opeak), e.peak & ((1 << W) - 1));
               checkOutput("ooffset", int'(ooffset), e.off);
            end
         end else if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL missed_sync at cycle %0d: got no osync, expected one at cycle %0d", cyc, e.cyc);
         end
      end
   end

   initial begin
      int seqA[8] = '{150, 300, 250, 300, 0, 0, 0, 0};
      logic [W-1:0] d;

      irst_n     = 1'b0;
      iena       = 1'b0;
      idat       = '0;
      ithreshold = W'(100);
      repeat (3) @(posedge iclk);
      @(negedge iclk);
      checkOutput("reset_osync", int'(osync), 0);
      checkOutput("reset_opeak", int'(opeak), 0);
      checkOutput("reset_ooffset", int'(ooffset), 0);
      checkOutput("reset_obusy", int'(obusy), 0);
      @(posedge iclk);
      #1;
      irst_n = 1'b1;
      monOn  = 1'b1;

      // Basic window with a tie: earliest 300 wins.
      doReset(W'(100));
      foreach (seqA[i]) applyStimulus(1'b1, W'(seqA[i]));
      repeat (12) applyStimulus(1'b1, '0);

      // Most negative sample as trigger.
      doReset(W'(100));
      applyStimulus(1'b1, W'(-2048));
      repeat (15) applyStimulus(1'b1, '0);

      // Same data with iena toggling; garbage on idle cycles.
      doReset(W'(100));
      foreach (seqA[i]) begin
         applyStimulus(1'b1, W'(seqA[i]));
         applyStimulus(1'b0, W'(1900));
      end
      repeat (12) applyStimulus(1'b1, '0);

      // Continuous 500s: holdoff then retrigger.
      doReset(W'(100));
      repeat (24) applyStimulus(1'b1, W'(500));
      repeat (12) applyStimulus(1'b1, '0);

      // Reset aborts a window at offset 3.
      doReset(W'(100));
      applyStimulus(1'b1, W'(200));
      applyStimulus(1'b1, W'(10));
      applyStimulus(1'b1, W'(20));
      applyStimulus(1'b1, W'(900));
      doReset(W'(100));
      repeat (20) applyStimulus(1'b1, '0);

      // Magnitude equal to threshold never triggers.
      doReset(W'(100));
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i % 2 == 0) ? W'(100) : W'(-100));

      // Randomized phases with fresh thresholds.
      for (int ph = 0; ph < 6; ph++) begin
         doReset(W'($urandom_range(50, 1500)));
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) d = W'($urandom);
            else d = W'(int'($urandom_range(0, 80)) - 40);
            applyStimulus($urandom_range(0, 9) < 7, d);
         end
      end

      repeat (12) applyStimulus(1'b0, '0);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
